// File: rtl/versatile_fifo_rd_port_if.sv
// versatile_fifo_rd_port_if
//   Bundle of the read-side FIFO signals shared between the read-port
//   controller, the async comparator, the dual-port RAM and the consumer.
//   Optional word-count signals exist only when VERSATILE_FIFO_RD_WORDCNT_EN
//   is defined.
//
//   Signals:
//     fifo_empty  comparator -> port   empty flag, already in rclk domain
//     rptr        port -> comparator   registered Gray read pointer
//     radr        port -> RAM          binary read address
//     re          port -> RAM          read enable
//     ram_q       RAM  -> port         read data (valid cycle after re)
//     dout        port -> consumer     data (pass-through of ram_q)
//     dout_valid  port -> consumer     dout holds an unconsumed word
//     dout_ready  consumer -> port     consumer accepts dout this cycle
//     cnt_clr     env -> port          synchronous word-count clear (opt.)
//     rd_count    port -> env          consumer transfer count (opt.)
//
//   Modports: master = read-port controller, slave = its environment.

interface versatile_fifo_rd_port_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] radr;
    logic                  re;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
`ifdef VERSATILE_FIFO_RD_WORDCNT_EN
    logic                  cnt_clr;
    logic [15:0]           rd_count;
`endif

`ifdef VERSATILE_FIFO_RD_WORDCNT_EN
    modport master (
        input  fifo_empty, ram_q, dout_ready, cnt_clr,
        output rptr, radr, re, dout, dout_valid, rd_count
    );
    modport slave (
        output fifo_empty, ram_q, dout_ready, cnt_clr,
        input  rptr, radr, re, dout, dout_valid, rd_count
    );
`else
    modport master (
        input  fifo_empty, ram_q, dout_ready,
        output rptr, radr, re, dout, dout_valid
    );
    modport slave (
        output fifo_empty, ram_q, dout_ready,
        input  rptr, radr, re, dout, dout_valid
    );
`endif
endinterface

// File: rtl/versatile_fifo_rd_port.sv
// versatile_fifo_rd_port
//   Read-side pointer and handshake controller of the versatile FIFO, fully
//   in the rclk domain. Issues RAM reads whenever the FIFO is not empty and
//   the output stage is free or being drained, keeps a binary read address
//   and publishes a registered Gray-coded read pointer to the comparator.
//   Sustains one word per cycle.
//
//   Ports:
//     rclk  read clock, all state on its rising edge
//     rst   asynchronous active-high reset
//     rd    versatile_fifo_rd_port_if.master (see interface file)
//
//   Option: define VERSATILE_FIFO_RD_WORDCNT_EN to add a 16-bit wrapping
//   count of consumer transfers (rd.rd_count) with synchronous clear
//   (rd.cnt_clr, priority over a simultaneous transfer).

module versatile_fifo_rd_port #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                          rclk,
    input  logic                          rst,
    versatile_fifo_rd_port_if.master      rd
);

    logic [ADDR_WIDTH-1:0] bin_q, bin_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  re_c;
    logic                  xfer_c;
    logic [DATA_WIDTH-1:0] dout_c;

    // Gated by rst so the RAM sees no read while reset is held, even though
    // the output register is already clear.
    assign re_c   = !rst && !rd.fifo_empty && (!dout_valid_q || rd.dout_ready);
    assign xfer_c = dout_valid_q && rd.dout_ready;

    always_comb begin
        bin_d        = bin_q;
        dout_valid_d = dout_valid_q;
        if (re_c) begin
            bin_d        = bin_q + 1'b1;
            dout_valid_d = 1'b1;
        end else if (xfer_c) begin
            dout_valid_d = 1'b0;
        end
        // Computed from the next binary value so rptr is a pure register
        // that stays exactly gray(bin_q).
        rptr_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            bin_q        <= '0;
            rptr_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            bin_q        <= bin_d;
            rptr_q       <= rptr_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout_c        = rd.ram_q;
    assign rd.dout       = dout_c;
    assign rd.dout_valid = dout_valid_q;
    assign rd.re         = re_c;
    assign rd.radr       = bin_q;
    assign rd.rptr       = rptr_q;

`ifdef VERSATILE_FIFO_RD_WORDCNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rd.cnt_clr) begin
            cnt_d = '0;
        end else if (xfer_c) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd.rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_versatile_fifo_rd_port.sv
// tb_versatile_fifo_rd_port
//   Self-checking bench for versatile_fifo_rd_port: a table of per-cycle
//   vectors plus hand-written sequences for streaming, Gray stepping,
//   backpressure, empty-during-transfer, asynchronous reset and the optional
//   word counter (VERSATILE_FIFO_RD_WORDCNT_EN).

module tb_versatile_fifo_rd_port;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    logic rclk;
    logic rst;

    versatile_fifo_rd_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rif ();

    versatile_fifo_rd_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .rclk (rclk),
        .rst  (rst),
        .rd   (rif.master)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // RAM model: returns the address as data, one cycle after re, held
    // while re is low.
    initial rif.ram_q = '0;
    always @(posedge rclk) begin
        if (rif.re) rif.ram_q <= DW'(rif.radr);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    function automatic logic [AW-1:0] gray(input logic [AW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        @(posedge rclk);
        #1;
        rst            = 1'b1;
        rif.fifo_empty = 1'b1;
        rif.dout_ready = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        exp_re;
        logic        exp_valid;
        int unsigned exp_radr;
        int unsigned exp_rptr;
        int unsigned exp_dout;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [AW-1:0] prev_rptr;
        logic [1:0]    qexp[5];
        int            qidx;
        logic [1:0]    qcur;

        // fe, rdy, re, valid, radr, rptr, dout (dout checked only if valid)
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 3, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 3, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 3, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 2, 2};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 6, 3};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 6, 3};

        qexp[0] = 2'b00; qexp[1] = 2'b01; qexp[2] = 2'b11;
        qexp[3] = 2'b10; qexp[4] = 2'b00;

        rst            = 1'b1;
        rif.fifo_empty = 1'b1;
        rif.dout_ready = 1'b0;
`ifdef VERSATILE_FIFO_RD_WORDCNT_EN
        rif.cnt_clr    = 1'b0;
`endif
        #1;
        chk("reset_re", rif.re, 0);
        chk("reset_radr", rif.radr, 0);
        do_reset();

        // Reset release with empty FIFO: nothing moves for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_re", rif.re, 0);
            chk("idle_rptr", rif.rptr, 0);
            chk("idle_valid", rif.dout_valid, 0);
        end

        // Table-driven handshake vectors.
        for (int i = 0; i < 10; i++) begin
            tick();
            rif.fifo_empty = vecs[i].fe;
            rif.dout_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_re", i), rif.re, vecs[i].exp_re);
            chk($sformatf("vec%0d_valid", i), rif.dout_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_radr", i), rif.radr, vecs[i].exp_radr);
            chk($sformatf("vec%0d_rptr", i), rif.rptr, vecs[i].exp_rptr);
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_dout", i), rif.dout, vecs[i].exp_dout);
        end

        // Full-rate stream through a complete pointer wrap.
        do_reset();
        rif.fifo_empty = 1'b0;
        rif.dout_ready = 1'b1;
        prev_rptr = '0;
        qidx = 0;
        for (int k = 1; k <= 66; k++) begin
            tick();
            chk("stream_valid", rif.dout_valid, 1);
            chk("stream_dout", rif.dout, (k - 1) % 64);
            chk("stream_rptr", rif.rptr, gray(AW'(k)));
            chk("stream_onebit", $countones(rif.rptr ^ prev_rptr), 1);
            qcur = rif.rptr[AW-1 -: 2];
            if (qcur != qexp[qidx]) begin
                if (qidx < 4) qidx++;
                chk("stream_quadrant", qcur, qexp[qidx]);
            end
            if (k == 31) chk("gray_31", rif.rptr, 6'b010000);
            if (k == 32) chk("gray_32", rif.rptr, 6'b110000);
            if (k == 63) chk("wrap_pre", rif.rptr, 6'b100000);
            if (k == 64) chk("wrap_post", rif.rptr, 6'b000000);
            prev_rptr = rif.rptr;
        end
        chk("quadrant_count", qidx, 4);

        // Backpressure: bin=2, dout=1 held while consumer stalls.
        rif.dout_ready = 1'b0;
        #1;
        chk("bp_re", rif.re, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_re_hold", rif.re, 0);
            chk("bp_valid", rif.dout_valid, 1);
            chk("bp_radr", rif.radr, 2);
            chk("bp_dout", rif.dout, 1);
        end
        rif.dout_ready = 1'b1;
        #1;
        chk("bp_resume_re", rif.re, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_resume_dout", rif.dout, 2 + i);
            chk("bp_resume_radr", rif.radr, 3 + i);
        end

        // Empty asserts in the cycle of a transfer.
        rif.fifo_empty = 1'b1;
        #1;
        chk("empty_xfer_re", rif.re, 0);
        tick();
        chk("empty_xfer_valid", rif.dout_valid, 0);
        chk("empty_xfer_radr", rif.radr, 5);
        chk("empty_xfer_rptr", rif.rptr, 7);

        // Reset asserted mid-stream at bin=17.
        do_reset();
        rif.fifo_empty = 1'b0;
        rif.dout_ready = 1'b1;
        repeat (17) tick();
        chk("mid_radr", rif.radr, 17);
`ifdef VERSATILE_FIFO_RD_WORDCNT_EN
        chk("mid_count", rif.rd_count, 16);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async_rptr", rif.rptr, 0);
        chk("async_valid", rif.dout_valid, 0);
        chk("async_re", rif.re, 0);
        chk("async_radr", rif.radr, 0);
`ifdef VERSATILE_FIFO_RD_WORDCNT_EN
        chk("async_count", rif.rd_count, 0);
`endif
        @(posedge rclk);
        #1;
        rst = 1'b0;

`ifdef VERSATILE_FIFO_RD_WORDCNT_EN
        repeat (3) tick();
        chk("cnt_run", rif.rd_count, 2);
        rif.cnt_clr = 1'b1;
        tick();
        chk("cnt_clr_priority", rif.rd_count, 0);
        rif.cnt_clr = 1'b0;
        tick();
        chk("cnt_after_clr", rif.rd_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/versatile_fifo_rd_port.md
# versatile_fifo_rd_port

Read-side pointer and handshake controller for the versatile FIFO. Runs entirely in the read clock domain. It consumes the synchronised `fifo_empty` flag from the async comparator, drives the dual-port RAM read port, and publishes the Gray-coded read pointer `rptr` that the comparator quadrant-decodes. It presents RAM data to the consumer through a valid/ready interface at full throughput.

## Interface
- `ADDR_WIDTH`, default 6: pointer/RAM address width; must be ≥ 2. Its top two bits form the comparator quadrant.
- `DATA_WIDTH`, default 8: data word width.

- `rclk` in 1: read clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fifo_empty` in 1: empty flag from the comparator, already in the `rclk` domain.
- `rptr` out `ADDR_WIDTH`: registered Gray-coded read pointer to the comparator.
- `radr` out `ADDR_WIDTH`: binary read address to the RAM.
- `re` out 1: RAM read enable.
- `ram_q` in `DATA_WIDTH`: RAM read data. It is valid the cycle after `re` and held while `re` is low.
- `dout` out `DATA_WIDTH`: consumer data. Combinational pass-through of `ram_q`.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `dout_ready` in 1: consumer accepts `dout` this cycle.

## Operation
- Internal binary counter `bin[ADDR_WIDTH-1:0]`. `radr = bin`. `rptr` is a register equal to `bin ^ (bin >> 1)` of the registered `bin`.
- `re = !fifo_empty && (!dout_valid || dout_ready)` (combinational).
- On a rising edge with `re`=1:
  - `bin <= bin+1` (mod 2^ADDR_WIDTH).
  - `rptr <= gray(bin+1)`.
  - `dout_valid <= 1`.
- On a rising edge with `re`=0 and `dout_valid && dout_ready`: `dout_valid <= 0`.
- Otherwise all state holds.
- A word transfers to the consumer on any edge where `dout_valid && dout_ready`.
- `rptr` changes by exactly one bit per increment, including wrap-around. Its top two bits step 00→01→11→10→00, which is the quadrant order the comparator expects.
- Underflow is impossible by construction. `re` is never asserted while `fifo_empty`=1.
- Simultaneous consume and refill (`dout_valid`, `dout_ready`, `!fifo_empty`): `re`=1, `dout_valid` stays 1, and the new word appears on `dout` the next cycle.
- `fifo_empty` rising in the same cycle as `dout_ready`: no read is issued, and `dout_valid` falls.

## Timing
- Reset values: `bin`=0, `rptr`=0, `dout_valid`=0.
- During reset: `re`=0, `radr`=0, `dout` = `ram_q`.
- Reset is asynchronous assert. It releases on the first `rclk` edge after `rst` falls. Reset mid-transfer discards any pending word.
- Latency from `re` sampled high to `dout_valid`=1 is 1 cycle. Latency from `re` to the `rptr` update is 1 cycle.
- Sustained throughput is 1 word/cycle while `fifo_empty`=0 and `dout_ready`=1.
- `rptr` is a pure register output, with no glitches toward the comparator.

## Configuration
- Macro: `VERSATILE_FIFO_RD_WORDCNT_EN`.
- Defined:
  - Adds input `cnt_clr` (1 bit, synchronous).
  - Adds output `rd_count[15:0]`, which counts consumer transfers (`dout_valid && dout_ready`) and wraps at 65535→0.
  - `cnt_clr` sets it to 0 next edge and has priority over a simultaneous transfer.
  - Reset value 0.
- Undefined: neither port exists, and there is no counter logic.

## Test plan
- Reset release with `fifo_empty`=1 → `re`=0, `rptr`=0, `dout_valid`=0 for 10 cycles.
- `fifo_empty`=0, `dout_ready`=1 for 64 cycles with a RAM model returning address as data:
  - `dout` = 0,1,2,…,63 on consecutive cycles.
  - `rptr` wraps 100000→000000.
  - The top two bits visit 00,01,11,10 in order.
- Gray check: drive 31 reads, then one more → `rptr` goes 010000→110000 with exactly one bit flip on every edge.
- Backpressure: `dout_valid`=1, `dout_ready`=0 for 5 cycles with `fifo_empty`=0 → `re`=0, `dout` and `bin` hold. When `dout_ready`=1, one word per cycle resumes.
- `fifo_empty` asserts in the cycle of a transfer → `re`=0, `dout_valid` drops next edge, `bin` unchanged.
- Reset asserted mid-stream at `bin`=17 → `rptr`=0 and `dout_valid`=0 immediately (asynchronously). With `VERSATILE_FIFO_RD_WORDCNT_EN` defined, `rd_count`=0 after reset and `cnt_clr` beats a simultaneous transfer.
